// File: rtl/priority_arbiter.sv
// Priority arbiter: highest prio wins, ties resolved round-robin,
// grants bounded by MAX_HOLD with a timeout pulse on forced release.
module priority_arbiter #(
    parameter  int NREQ     = 8,
    parameter  int PW       = 2,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*PW-1:0] prio,
    input  logic               done,
    output logic [NREQ-1:0]    gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] ID_LAST   = IW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_id;
    logic [IW-1:0]   r_rr_ptr;
    logic            r_gnt_valid;
    logic            r_timeout;
    logic [HW-1:0]   r_hold_cnt;

    logic [IW-1:0]   w_win;
    logic            w_keep;
    logic            w_at_limit;
    logic            w_rel;
    logic [IW-1:0]   w_next_ptr;

    // Scan from rr_ptr; strict '>' keeps the first tied requester.
    always_comb begin : pick
        logic [PW-1:0] v_best;
        logic          v_found;
        int            v_idx;
        w_win   = r_rr_ptr;
        v_best  = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) v_idx -= NREQ;
            if (req[v_idx] &&
                (!v_found || prio[PW*v_idx +: PW] > v_best)) begin
                v_found = 1'b1;
                v_best  = prio[PW*v_idx +: PW];
                w_win   = IW'(v_idx);
            end
        end
    end

    assign w_keep     = req[r_gnt_id] & ~done;
    assign w_at_limit = (r_hold_cnt == HOLD_LAST);
    assign w_rel      = ~w_keep | w_at_limit;
    assign w_next_ptr = (r_gnt_id == ID_LAST) ? '0 : r_gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_rr_ptr    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (|req) begin
                        r_state     <= GRANT;
                        r_gnt       <= NREQ'(1) << w_win;
                        r_gnt_id    <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_rel) begin
                        r_state     <= IDLE;
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        // Only a pure hold-limit release still wants the bus.
                        r_timeout   <= w_keep;
                        r_rr_ptr    <= w_next_ptr;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 1'b1;
                        r_timeout   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 8, number of requesters (one per priority block).
REQ-002 The block SHALL have parameter PW, default 2, per-requester priority width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, maximum grant length in cycles; legal range is 1 or more.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-006 The block SHALL have port req, input, NREQ, request lines, where bit i is requester i.
REQ-007 The block SHALL have port prio, input, NREQ*PW, the concatenated priorityOut values, where prio[PW*i+PW-1:PW*i] belongs to requester i.
REQ-008 The block SHALL have port done, input, 1, release strobe from the current grant holder.
REQ-009 The block SHALL have port gnt, output, NREQ, a registered one-hot grant.
REQ-010 The block SHALL have port gnt_id, output, clog2(NREQ), a registered index of the granted requester.
REQ-011 The block SHALL have port gnt_valid, output, 1, registered, high while any grant is held.
REQ-012 The block SHALL have port timeout, output, 1, registered, a 1-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT, and gnt_valid SHALL be 1 exactly in GRANT.
REQ-014 In IDLE with req nonzero at an edge, the FSM SHALL move to GRANT at that edge with gnt, gnt_id and gnt_valid updated, giving 1-cycle latency.
REQ-015 In IDLE with req equal to zero, the FSM SHALL stay in IDLE with gnt=0.
REQ-016 Winner selection SHALL take the highest numeric prio among asserted req bits, where a larger value means higher priority.
REQ-017 Ties SHALL go to the first tied requester found scanning upward from rr_ptr and wrapping from NREQ-1 to 0.
REQ-018 Priorities SHALL be evaluated only at the IDLE-to-GRANT edge; prio changes during GRANT SHALL NOT affect the holder.
REQ-019 hold_cnt SHALL be cleared to 0 on entry to GRANT and SHALL increment by 1 each cycle spent in GRANT.
REQ-020 In GRANT, a release SHALL occur at an edge where done=1, or req[gnt_id]=0, or hold_cnt=MAX_HOLD-1.
REQ-021 On a release the FSM SHALL go to IDLE, gnt SHALL become 0, and rr_ptr SHALL become (gnt_id+1) mod NREQ.
REQ-022 At least one idle cycle SHALL separate consecutive grants.
REQ-023 timeout SHALL be 1 for exactly the cycle after a release caused solely by hold_cnt=MAX_HOLD-1.
REQ-024 If done or req[gnt_id]=0 coincides with the hold limit, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-025 gnt SHALL always equal one-hot(gnt_id) while gnt_valid=1, and SHALL be all-zero otherwise.
REQ-026 done asserted in IDLE SHALL be ignored.
REQ-027 With MAX_HOLD=1, every grant SHALL last exactly 1 cycle, and timeout SHALL pulse unless done=1 or req[gnt_id]=0 at release.

Reset
REQ-028 On an edge with reset=0, the block SHALL set state to IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, rr_ptr=0 and hold_cnt=0.
REQ-029 Reset SHALL take precedence over every other event, including mid-grant; the grant SHALL be dropped at that edge with no timeout pulse.
REQ-030 In the first cycle after reset deasserts, the block SHALL be able to arbitrate.

Verification
REQ-031 The bench SHALL check: req=8'h05, prio[1:0]=1, prio[5:4]=3 -> next cycle gnt=8'h04, gnt_id=2; done=1 -> next cycle gnt=0, rr_ptr=3.
REQ-032 The bench SHALL check: all prio=2, req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0, with one idle cycle between grants.
REQ-033 The bench SHALL check: MAX_HOLD=16, req=8'h01 held, done=0 -> gnt=8'h01 for 16 cycles, then gnt=0 with timeout=1 for one cycle, then regrant of 0.
REQ-034 The bench SHALL check: done=1 on the same edge as hold_cnt=15 -> release with timeout=0.
REQ-035 The bench SHALL check: grant to requester 3, then prio[7:6] changed to 0 and req[7] with prio=3 asserted mid-grant -> holder unchanged until done.
REQ-036 The bench SHALL check: reset=0 asserted during GRANT -> next cycle gnt=0, gnt_valid=0, timeout=0, and rr_ptr=0.
